// File: rtl/twi_mon_pkg.sv
// Shared types and byte-selection helpers for the TWI monitor transmit path.
package twi_mon_pkg;

  typedef enum logic [1:0] {
    TAG_FRAME = 2'd0,
    TAG_START = 2'd1,
    TAG_STOP  = 2'd2
  } entry_tag_t;

  typedef struct packed {
    entry_tag_t  tag;
    logic [17:0] payload;
  } tx_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PULSE,
    WAIT_HI,
    WAIT_LO
  } tx_sched_state_t;

  localparam logic [1:0] FRAME_LAST_IDX = 2'd2;

  // Frame layout is {addr[6:0], rw, ack0, data[7:0], ack1}; acks travel together in the last byte.
  function automatic logic [7:0] select_byte(input entry_tag_t tag,
                                             input logic [17:0] payload,
                                             input logic [1:0] idx,
                                             input logic [7:0] start_mark,
                                             input logic [7:0] stop_mark);
    logic [7:0] b;
    b = 8'h00;
    case (tag)
      TAG_FRAME: begin
        case (idx)
          2'd0:    b = payload[17:10];
          2'd1:    b = payload[8:1];
          default: b = {6'b0, payload[9], payload[0]};
        endcase
      end
      TAG_START: b = start_mark;
      TAG_STOP:  b = stop_mark;
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic is_last_byte(input entry_tag_t tag, input logic [1:0] idx);
    return (tag != TAG_FRAME) || (idx == FRAME_LAST_IDX);
  endfunction

endpackage

// File: rtl/twi_entry_fifo.sv
// Synchronous FIFO of tagged transmit entries; head entry is visible combinationally.
module twi_entry_fifo
  import twi_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  tx_entry_t                wdata,
  input  logic                     pop,
  output tx_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  tx_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/twi_tx_scheduler.sv
// Orders captured TWI frames and start/stop events into one FIFO and feeds them to the UART a byte at a time.
module twi_tx_scheduler
  import twi_mon_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] START_MARK = 8'h53,
  parameter logic [7:0] STOP_MARK  = 8'h50
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_valid,
  input  logic [17:0]            frame_data,
  input  logic                   start_evt,
  input  logic                   stop_evt,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             drop_count
);

  tx_sched_state_t state_q, state_d;
  entry_tag_t      tag_q, tag_d;
  logic [17:0]     payload_q, payload_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            wait_cnt_q, wait_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            start_pend_q, start_pend_d;
  logic            stop_pend_q, stop_pend_d;
  logic [7:0]      drop_q, drop_d;

  tx_entry_t       wr_entry, head;
  logic            wr_req, sel_start, sel_stop;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic            wr_drop, start_dup, stop_dup;
  logic [1:0]      drop_inc;
  logic [8:0]      drop_sum;

  twi_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (wr_entry),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Single write port: a frame always wins, then a pending stop, then a pending start.
  always_comb begin
    wr_req    = 1'b0;
    sel_start = 1'b0;
    sel_stop  = 1'b0;
    wr_entry  = '{tag: TAG_FRAME, payload: '0};
    if (enable) begin
      if (frame_valid) begin
        wr_req           = 1'b1;
        wr_entry.payload = frame_data;
      end else if (stop_pend_q) begin
        wr_req       = 1'b1;
        sel_stop     = 1'b1;
        wr_entry.tag = TAG_STOP;
      end else if (start_pend_q) begin
        wr_req       = 1'b1;
        sel_start    = 1'b1;
        wr_entry.tag = TAG_START;
      end
    end
  end

  assign fifo_pop  = (state_q == IDLE) & enable & ~fifo_empty & ~tx_busy;
  assign wr_drop   = wr_req & fifo_full & ~fifo_pop;
  assign fifo_push = wr_req & ~wr_drop;

  // A flag being consumed this cycle can be re-armed by a fresh event without loss.
  assign start_dup    = start_evt & start_pend_q & ~sel_start;
  assign stop_dup     = stop_evt & stop_pend_q & ~sel_stop;
  assign start_pend_d = start_evt | (start_pend_q & ~sel_start);
  assign stop_pend_d  = stop_evt | (stop_pend_q & ~sel_stop);

  assign drop_inc = 2'(wr_drop) + 2'(start_dup) + 2'(stop_dup);
  assign drop_sum = 9'(drop_q) + 9'(drop_inc);
  assign drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    payload_d  = payload_q;
    byte_idx_d = byte_idx_q;
    wait_cnt_d = wait_cnt_q;
    tx_data_d  = tx_data_q;
    tx_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          tag_d      = head.tag;
          payload_d  = head.payload;
          byte_idx_d = 2'd0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = select_byte(tag_q, payload_q, byte_idx_q, START_MARK, STOP_MARK);
        state_d   = PULSE;
      end
      PULSE: begin
        if (!tx_busy) begin
          tx_start   = 1'b1;
          wait_cnt_d = 1'b0;
          state_d    = WAIT_HI;
        end
      end
      // Give up on seeing busy after two cycles so a missed handshake cannot stall the queue.
      WAIT_HI: begin
        if (tx_busy || wait_cnt_q) state_d = WAIT_LO;
        else wait_cnt_d = 1'b1;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (is_last_byte(tag_q, byte_idx_q)) begin
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      tag_q        <= TAG_FRAME;
      payload_q    <= '0;
      byte_idx_q   <= '0;
      wait_cnt_q   <= 1'b0;
      tx_data_q    <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      payload_q    <= payload_d;
      byte_idx_q   <= byte_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      tx_data_q    <= tx_data_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      drop_q       <= drop_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_twi_tx_scheduler.sv
// Self-checking bench for twi_tx_scheduler: directed scenarios plus randomized bursts against a queue-based byte model.
module tb_twi_tx_scheduler;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          frame_valid;
  logic [17:0]   frame_data;
  logic          start_evt;
  logic          stop_evt;
  logic          tx_busy;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic [LW-1:0] fifo_level;
  logic [7:0]    drop_count;

  int            errors;
  int            checks;
  int            cyc;
  int            busyCnt;
  int            busyViol;
  int            expDrop;
  logic          holdBusy;
  logic          uartMute;
  logic [7:0]    obsBytes[$];
  int            obsCyc[$];
  logic [7:0]    expBytes[$];

  twi_tx_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .start_evt   (start_evt),
    .stop_evt    (stop_evt),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .fifo_level  (fifo_level),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy rises the cycle after tx_start and stays high for 10 cycles.
  always @(posedge clk) begin
    if (busyCnt > 0) busyCnt <= busyCnt - 1;
    else if (tx_start && !uartMute) busyCnt <= 10;
  end
  assign tx_busy = (busyCnt != 0) || holdBusy;

  always @(negedge clk) begin
    if (tx_start) begin
      obsBytes.push_back(tx_data);
      obsCyc.push_back(cyc);
      if (tx_busy) busyViol <= busyViol + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearObs;
    obsBytes.delete();
    obsCyc.delete();
    expBytes.delete();
  endtask

  function automatic void addFrame(input logic [17:0] p);
    expBytes.push_back(p[17:10]);
    expBytes.push_back(p[8:1]);
    expBytes.push_back({6'b0, p[9], p[0]});
  endfunction

  task automatic waitBytes(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obsBytes.size() < n && k < budget) begin
      tick;
      k++;
    end
    if (obsBytes.size() < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got %0d bytes, expected %0d", tag, obsBytes.size(), n);
    end
  endtask

  task automatic pulseFrame(input logic [17:0] p);
    frame_data  = p;
    frame_valid = 1'b1;
    tick;
    frame_valid = 1'b0;
    frame_data  = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++;
    if (fifo_level !== LW'(0)) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++;
    if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_count); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_frame;
    int c0;
    clearObs;
    expBytes.push_back(8'hA0);
    expBytes.push_back(8'hCA);
    expBytes.push_back(8'h01);
    c0 = cyc;
    pulseFrame(18'b1010000_0_0_11001010_1);
    waitBytes(3, 120, "single");
    repeat (20) tick;
    checks++;
    if (obsBytes.size() != 3) begin errors++; $display("[TB] FAIL single_count: got %0d expected 3", obsBytes.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL single_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
    checks++;
    if (obsCyc.size() == 0 || obsCyc[0] != c0 + 3) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d expected %0d", (obsCyc.size() == 0) ? -1 : obsCyc[0], c0 + 3);
    end
    checks++;
    if (fifo_level !== LW'(0)) begin errors++; $display("[TB] FAIL single_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_event_order;
    logic [17:0] p;
    clearObs;
    p = 18'($urandom());
    expBytes.push_back(8'h53);
    addFrame(p);
    expBytes.push_back(8'h50);
    start_evt = 1'b1; tick; start_evt = 1'b0;
    repeat (2) tick;
    pulseFrame(p);
    repeat (2) tick;
    stop_evt = 1'b1; tick; stop_evt = 1'b0;
    waitBytes(5, 200, "order");
    repeat (20) tick;
    checks++;
    if (obsBytes.size() != 5) begin errors++; $display("[TB] FAIL order_count: got %0d expected 5", obsBytes.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL order_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL order_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
  endtask

  task automatic test_same_cycle;
    logic [17:0] p;
    clearObs;
    p = 18'($urandom());
    addFrame(p);
    expBytes.push_back(8'h50);
    frame_data  = p;
    frame_valid = 1'b1;
    stop_evt    = 1'b1;
    tick;
    frame_valid = 1'b0;
    stop_evt    = 1'b0;
    frame_data  = '0;
    tick;
    checks++;
    if (fifo_level !== LW'(1)) begin errors++; $display("[TB] FAIL same_level: got %0d expected 1", fifo_level); end
    waitBytes(4, 200, "same");
    repeat (20) tick;
    checks++;
    if (obsBytes.size() != 4) begin errors++; $display("[TB] FAIL same_count: got %0d expected 4", obsBytes.size()); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL same_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL same_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
    checks++;
    if (drop_count !== 8'(expDrop)) begin errors++; $display("[TB] FAIL same_drop: got %0d expected %0d", drop_count, expDrop); end
  endtask

  task automatic test_missed_busy;
    logic [17:0] p;
    clearObs;
    uartMute = 1'b1;
    p = 18'($urandom());
    addFrame(p);
    pulseFrame(p);
    waitBytes(3, 60, "mute");
    repeat (10) tick;
    uartMute = 1'b0;
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL mute_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL mute_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (i >= obsCyc.size() || obsCyc[i] - obsCyc[i-1] != 5) begin
        errors++;
        $display("[TB] FAIL mute_spacing%0d: got %0d expected 5", i, (i >= obsCyc.size()) ? -1 : obsCyc[i] - obsCyc[i-1]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [17:0] p;
    clearObs;
    holdBusy = 1'b1;
    tick;
    for (int i = 0; i < DEPTH + 2; i++) begin
      p = 18'($urandom());
      if (i < DEPTH) addFrame(p);
      pulseFrame(p);
    end
    tick;
    expDrop = expDrop + 2;
    checks++;
    if (fifo_level !== LW'(DEPTH)) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected %0d", fifo_level, DEPTH); end
    checks++;
    if (drop_count !== 8'(expDrop)) begin errors++; $display("[TB] FAIL ovf_drop: got %0d expected %0d", drop_count, expDrop); end
    holdBusy = 1'b0;
    waitBytes(3 * DEPTH, 60 * DEPTH, "ovf");
    repeat (50) tick;
    checks++;
    if (obsBytes.size() != 3 * DEPTH) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected %0d", obsBytes.size(), 3 * DEPTH); end
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL ovf_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL ovf_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
  endtask

  task automatic test_reset_mid;
    clearObs;
    pulseFrame(18'($urandom()));
    pulseFrame(18'($urandom()));
    waitBytes(2, 60, "rstmid");
    repeat (4) tick;
    reset = 1'b1;
    tick;
    expDrop = 0;
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_tx_start: got %b expected 0", tx_start); end
    checks++;
    if (fifo_level !== LW'(0)) begin errors++; $display("[TB] FAIL rstmid_level: got %0d expected 0", fifo_level); end
    checks++;
    if (drop_count !== 8'd0) begin errors++; $display("[TB] FAIL rstmid_drop: got %0d expected 0", drop_count); end
    reset = 1'b0;
    repeat (60) tick;
    checks++;
    if (obsBytes.size() != 2) begin errors++; $display("[TB] FAIL rstmid_count: got %0d expected 2", obsBytes.size()); end
  endtask

  task automatic test_enable;
    logic [17:0] pa, pb;
    clearObs;
    pa = 18'($urandom());
    pb = 18'($urandom());
    addFrame(pa);
    addFrame(pb);
    pulseFrame(pa);
    pulseFrame(pb);
    waitBytes(1, 20, "enable_first");
    enable = 1'b0;
    waitBytes(3, 80, "enable_hold");
    repeat (50) tick;
    checks++;
    if (obsBytes.size() != 3) begin errors++; $display("[TB] FAIL enable_hold_count: got %0d expected 3", obsBytes.size()); end
    checks++;
    if (fifo_level !== LW'(1)) begin errors++; $display("[TB] FAIL enable_hold_level: got %0d expected 1", fifo_level); end
    enable = 1'b1;
    waitBytes(6, 120, "enable_resume");
    repeat (20) tick;
    for (int i = 0; i < expBytes.size(); i++) begin
      checks++;
      if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL enable_byte%0d: got none expected %h", i, expBytes[i]); end
      else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL enable_byte%0d: got %h expected %h", i, obsBytes[i], expBytes[i]); end
    end
  endtask

  // Each burst issues at most DEPTH writes, so the model never needs to know when entries leave.
  task automatic test_random;
    bit          sp, tp, fv, se, pe, selStart, selStop;
    int          writes;
    logic [17:0] p;
    for (int burst = 0; burst < 12; burst++) begin
      clearObs;
      sp = 0;
      tp = 0;
      writes = 0;
      for (int c = 0; c < 14; c++) begin
        fv = (c < 10) && ($urandom_range(0, 2) == 0);
        se = (c < 10) && ($urandom_range(0, 3) == 0);
        pe = (c < 10) && ($urandom_range(0, 3) == 0);
        if (writes + int'(sp) + int'(tp) + int'(fv) + int'(se) + int'(pe) > DEPTH) begin
          fv = 0;
          se = 0;
          pe = 0;
        end
        p = 18'($urandom());
        frame_valid = fv;
        frame_data  = fv ? p : 18'd0;
        start_evt   = se;
        stop_evt    = pe;
        selStart = 0;
        selStop  = 0;
        if (fv) begin addFrame(p); writes++; end
        else if (tp) begin expBytes.push_back(8'h50); tp = 0; selStop = 1; writes++; end
        else if (sp) begin expBytes.push_back(8'h53); sp = 0; selStart = 1; writes++; end
        if (se) begin
          if (sp && !selStart) expDrop = (expDrop < 255) ? expDrop + 1 : 255;
          else sp = 1;
        end
        if (pe) begin
          if (tp && !selStop) expDrop = (expDrop < 255) ? expDrop + 1 : 255;
          else tp = 1;
        end
        tick;
      end
      frame_valid = 0;
      frame_data  = '0;
      start_evt   = 0;
      stop_evt    = 0;
      waitBytes(expBytes.size(), 20 * expBytes.size() + 40, "rand");
      repeat (20) tick;
      checks++;
      if (obsBytes.size() != expBytes.size()) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", burst, obsBytes.size(), expBytes.size()); end
      for (int i = 0; i < expBytes.size(); i++) begin
        checks++;
        if (i >= obsBytes.size()) begin errors++; $display("[TB] FAIL rand%0d_byte%0d: got none expected %h", burst, i, expBytes[i]); end
        else if (obsBytes[i] !== expBytes[i]) begin errors++; $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", burst, i, obsBytes[i], expBytes[i]); end
      end
      checks++;
      if (drop_count !== 8'(expDrop)) begin errors++; $display("[TB] FAIL rand%0d_drop: got %0d expected %0d", burst, drop_count, expDrop); end
    end
  endtask

  task automatic test_saturation;
    clearObs;
    expBytes.push_back(8'h53);
    enable    = 1'b0;
    start_evt = 1'b1;
    repeat (300) tick;
    start_evt = 1'b0;
    expDrop   = (expDrop + 299 > 255) ? 255 : expDrop + 299;
    tick;
    checks++;
    if (drop_count !== 8'(expDrop)) begin errors++; $display("[TB] FAIL sat_drop: got %0d expected %0d", drop_count, expDrop); end
    enable = 1'b1;
    waitBytes(1, 40, "sat");
    repeat (20) tick;
    checks++;
    if (obsBytes.size() != 1 || obsBytes[0] !== 8'h53) begin
      errors++;
      $display("[TB] FAIL sat_marker: got %0d bytes first %h, expected 1 byte 53", obsBytes.size(), (obsBytes.size() > 0) ? obsBytes[0] : 8'h00);
    end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    busyCnt     = 0;
    busyViol    = 0;
    expDrop     = 0;
    holdBusy    = 1'b0;
    uartMute    = 1'b0;
    reset       = 1'b1;
    enable      = 1'b1;
    frame_valid = 1'b0;
    frame_data  = '0;
    start_evt   = 1'b0;
    stop_evt    = 1'b0;

    test_reset;
    test_single_frame;
    test_event_order;
    test_same_cycle;
    test_missed_busy;
    test_overflow;
    test_reset_mid;
    test_enable;
    test_random;
    test_saturation;

    checks++;
    if (busyViol != 0) begin errors++; $display("[TB] FAIL start_while_busy: got %0d occurrences expected 0", busyViol); end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
